// File: rtl/even_fwd_unit.sv
// even_fwd_unit: operand-forwarding stage for the even pipe.
// For each of the three source operands it snoops the seven packed stage
// buses and the WB write port, then selects the youngest matching result
// or falls back to register-file data. Resolved operands are registered
// into execute. Issue stalls while any operand's youngest producer has
// not yet produced its result.
// Optional build macro: FWD_STALL_CNT_EN adds a saturating count of stall
// cycles on stall_cnt. Without it, stall_cnt is tied to zero.

// Single-operand resolver. Stage buses are ordered youngest first:
// bus[0] is stage 1.
module even_fwd_operand #(
    parameter int NSTAGE = 7
) (
    input  logic [6:0]                  addr,
    input  logic [127:0]                rf,
    input  logic [NSTAGE-1:0][142:0]    bus,
    input  logic [6:0]                  wb_addr,
    input  logic [127:0]                wb_data,
    input  logic                        wb_en,
    output logic [127:0]                data,
    output logic                        hazard
);
    // Walk from oldest to youngest so the youngest match has the final say on
    // both data and readiness. An older ready match never masks a pending younger one.
    always_comb begin
        data   = rf;
        hazard = 1'b0;
        if (wb_en && wb_addr == addr) data = wb_data;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (bus[k][142] && bus[k][137:131] == addr) begin
                data   = bus[k][130:3];
                hazard = int'(bus[k][141:138]) > (k + 1);
            end
        end
    end
endmodule

module even_fwd_unit #(
    parameter int MAX_STALL = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [6:0]    ra_addr,
    input  logic [6:0]    rb_addr,
    input  logic [6:0]    rc_addr,
    input  logic [127:0]  ra_rf,
    input  logic [127:0]  rb_rf,
    input  logic [127:0]  rc_rf,
    input  logic [142:0]  packed_1stage,
    input  logic [142:0]  packed_2stage,
    input  logic [142:0]  packed_3stage,
    input  logic [142:0]  packed_4stage,
    input  logic [142:0]  packed_5stage,
    input  logic [142:0]  packed_6stage,
    input  logic [142:0]  packed_7stage,
    input  logic [6:0]    wb_addr,
    input  logic [127:0]  wb_data,
    input  logic          wb_en,
    output logic          ex_valid,
    output logic [127:0]  ex_ra_data,
    output logic [127:0]  ex_rb_data,
    output logic [127:0]  ex_rc_data,
    output logic          stall,
    output logic          stall_timeout,
    output logic [31:0]   stall_cnt
);
    // Seven packed stage buses are snooped.
    localparam int NSTAGE   = 7;
    localparam int NOPS     = 3;
    localparam int CW       = $clog2(MAX_STALL + 1);

    typedef enum logic {RUN, STALL} state_t;

    logic [NSTAGE-1:0][142:0] stage_bus;
    logic [NOPS-1:0][6:0]     src_addr;
    logic [NOPS-1:0][127:0]   src_rf;
    logic [NOPS-1:0][127:0]   src_data;
    logic [NOPS-1:0]          op_hazard;
    logic                     hazard;
    state_t                   state;
    logic [CW-1:0]            run_cnt;

    assign stage_bus = {packed_7stage, packed_6stage, packed_5stage, packed_4stage,
                        packed_3stage, packed_2stage, packed_1stage};
    assign src_addr  = {rc_addr, rb_addr, ra_addr};
    assign src_rf    = {rc_rf, rb_rf, ra_rf};

    // The execution-unit tag field is not needed for forwarding.
    logic unused_unit;
    assign unused_unit = ^{packed_1stage[2:0], packed_2stage[2:0], packed_3stage[2:0],
                           packed_4stage[2:0], packed_5stage[2:0], packed_6stage[2:0],
                           packed_7stage[2:0]};

    for (genvar i = 0; i < NOPS; i++) begin : g_op
        even_fwd_operand #(.NSTAGE(NSTAGE)) u_op (
            .addr    (src_addr[i]),
            .rf      (src_rf[i]),
            .bus     (stage_bus),
            .wb_addr (wb_addr),
            .wb_data (wb_data),
            .wb_en   (wb_en),
            .data    (src_data[i]),
            .hazard  (op_hazard[i])
        );
    end

    assign hazard      = issue_valid && (|op_hazard);
    assign issue_ready = issue_valid && !hazard;

    // Execute-stage operand registers plus the RUN/STALL controller.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            ex_valid      <= 1'b0;
            ex_ra_data    <= '0;
            ex_rb_data    <= '0;
            ex_rc_data    <= '0;
            stall         <= 1'b0;
            stall_timeout <= 1'b0;
            run_cnt       <= '0;
        end else begin
            ex_valid <= issue_ready;
            if (issue_ready) begin
                ex_ra_data <= src_data[0];
                ex_rb_data <= src_data[1];
                ex_rc_data <= src_data[2];
            end
            case (state)
                RUN: begin
                    if (hazard) begin
                        state   <= STALL;
                        stall   <= 1'b1;
                        run_cnt <= CW'(1);
                    end
                end
                STALL: begin
                    if (hazard) begin
                        // A hazard cycle that arrives with the count already saturated
                        // is stall cycle MAX_STALL+1.
                        if (run_cnt == CW'(MAX_STALL)) stall_timeout <= 1'b1;
                        else                          run_cnt       <= run_cnt + CW'(1);
                    end else begin
                        state   <= RUN;
                        stall   <= 1'b0;
                        run_cnt <= '0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef FWD_STALL_CNT_EN
    // Saturating count of all cycles spent with stall asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          stall_cnt <= '0;
        else if (stall && ~&stall_cnt)     stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_even_fwd_unit.sv
// Directed bench for even_fwd_unit: reset, RF path, stage forwarding,
// stall/advance, priority, WB path, timeout and reset during a stall.
module tb_even_fwd_unit;
    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic          issue_ready;
    logic [6:0]    ra_addr, rb_addr, rc_addr;
    logic [127:0]  ra_rf, rb_rf, rc_rf;
    logic [142:0]  bus [1:7];
    logic [6:0]    wb_addr;
    logic [127:0]  wb_data;
    logic          wb_en;
    logic          ex_valid;
    logic [127:0]  ex_ra_data, ex_rb_data, ex_rc_data;
    logic          stall, stall_timeout;
    logic [31:0]   stall_cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] A = 128'hAAAA_0000_1111_2222_3333_4444_5555_0001;
    localparam logic [127:0] B = 128'hBBBB_0000_1111_2222_3333_4444_5555_0002;
    localparam logic [127:0] C = 128'hCCCC_0000_1111_2222_3333_4444_5555_0003;
    localparam logic [127:0] X = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [127:0] Y = 128'h0000_FFFF_0000_FFFF_DEAD_BEEF_CAFE_F00D;
    localparam logic [127:0] Z = 128'h5A5A_5A5A_A5A5_A5A5_1357_9BDF_2468_ACE0;

    always #5 clk = ~clk;

    even_fwd_unit dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
        .ra_rf(ra_rf), .rb_rf(rb_rf), .rc_rf(rc_rf),
        .packed_1stage(bus[1]), .packed_2stage(bus[2]), .packed_3stage(bus[3]),
        .packed_4stage(bus[4]), .packed_5stage(bus[5]), .packed_6stage(bus[6]),
        .packed_7stage(bus[7]),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_en(wb_en),
        .ex_valid(ex_valid), .ex_ra_data(ex_ra_data), .ex_rb_data(ex_rb_data),
        .ex_rc_data(ex_rc_data), .stall(stall), .stall_timeout(stall_timeout),
        .stall_cnt(stall_cnt)
    );

    function automatic logic [142:0] mk(input logic wr, input logic [3:0] lat,
                                        input logic [6:0] dst, input logic [127:0] res);
        return {wr, lat, dst, res, 3'b010};
    endfunction

    task automatic clear_inputs();
        for (int k = 1; k <= 7; k++) bus[k] = '0;
        issue_valid = 1'b0;
        ra_addr = 7'd1; rb_addr = 7'd2; rc_addr = 7'd3;
        ra_rf = A; rb_rf = B; rc_rf = C;
        wb_addr = 7'd0; wb_data = '0; wb_en = 1'b0;
    endtask

    task automatic shift_bus();
        for (int k = 7; k >= 2; k--) bus[k] = bus[k-1];
        bus[1] = '0;
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        issue_valid = 1'b1;
        #3;
        total++; if (ex_valid !== 1'b0)      begin bad++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
        total++; if (stall !== 1'b0)         begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        total++; if (stall_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b exp=0", stall_timeout); end
        total++; if (ex_ra_data !== '0)      begin bad++; $display("FAIL reset_ex_ra got=%h exp=0", ex_ra_data); end
        total++; if (stall_cnt !== 32'd0)    begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        total++; if (issue_ready !== 1'b1)   begin bad++; $display("FAIL reset_issue_ready got=%0b exp=1", issue_ready); end
        tick();
        rst = 1'b1;
        issue_valid = 1'b0;
        tick();
    endtask

    task automatic test_rf_path();
        clear_inputs();
        issue_valid = 1'b1;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rf_issue_ready got=%0b exp=1", issue_ready); end
        tick();
        issue_valid = 1'b0;
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL rf_ex_valid got=%0b exp=1", ex_valid); end
        total++; if (ex_ra_data !== A)  begin bad++; $display("FAIL rf_ex_ra got=%h exp=%h", ex_ra_data, A); end
        total++; if (ex_rb_data !== B)  begin bad++; $display("FAIL rf_ex_rb got=%h exp=%h", ex_rb_data, B); end
        total++; if (ex_rc_data !== C)  begin bad++; $display("FAIL rf_ex_rc got=%h exp=%h", ex_rc_data, C); end
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL idle_ex_valid got=%0b exp=0", ex_valid); end
        total++; if (ex_ra_data !== A)  begin bad++; $display("FAIL idle_ex_ra_hold got=%h exp=%h", ex_ra_data, A); end
    endtask

    task automatic test_stage_fwd();
        clear_inputs();
        ra_addr = 7'd5;
        bus[2] = mk(1'b1, 4'd2, 7'd5, X);
        bus[1] = mk(1'b0, 4'd9, 7'd5, Y);   // RegWr=0: must be ignored
        bus[3] = mk(1'b1, 4'd0, 7'd3, Z);   // rc: latency 0 always ready
        issue_valid = 1'b1;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL fwd_issue_ready got=%0b exp=1", issue_ready); end
        tick();
        issue_valid = 1'b0;
        total++; if (ex_ra_data !== X) begin bad++; $display("FAIL fwd_ex_ra got=%h exp=%h", ex_ra_data, X); end
        total++; if (ex_rc_data !== Z) begin bad++; $display("FAIL fwd_ex_rc got=%h exp=%h", ex_rc_data, Z); end
        total++; if (stall !== 1'b0)   begin bad++; $display("FAIL fwd_stall got=%0b exp=0", stall); end
        tick();
    endtask

    task automatic test_stall_advance();
        int stall_hi;
        logic [31:0] cnt0;
        clear_inputs();
        cnt0 = stall_cnt;
        ra_addr = 7'd5;
        bus[1] = mk(1'b1, 4'd4, 7'd5, Y);
        bus[3] = mk(1'b1, 4'd0, 7'd5, X);
        issue_valid = 1'b1;
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL adv_hazard got=%0b exp=0", issue_ready); end
        stall_hi = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (stall === 1'b1) stall_hi++;
            shift_bus();
            #1;
        end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL adv_ready_stage4 got=%0b exp=1", issue_ready); end
        tick();
        issue_valid = 1'b0;
        total++; if (stall_hi != 3)      begin bad++; $display("FAIL adv_stall_cycles got=%0d exp=3", stall_hi); end
        total++; if (ex_valid !== 1'b1)  begin bad++; $display("FAIL adv_ex_valid got=%0b exp=1", ex_valid); end
        total++; if (ex_ra_data !== Y)   begin bad++; $display("FAIL adv_ex_ra got=%h exp=%h", ex_ra_data, Y); end
        total++; if (stall !== 1'b0)     begin bad++; $display("FAIL adv_stall_clear got=%0b exp=0", stall); end
`ifdef FWD_STALL_CNT_EN
        total++; if (stall_cnt !== cnt0 + 32'd3) begin bad++; $display("FAIL adv_stall_cnt got=%0d exp=%0d", stall_cnt, cnt0 + 32'd3); end
`else
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL adv_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
        tick();
    endtask

    task automatic test_priority();
        clear_inputs();
        ra_addr = 7'd9; rb_addr = 7'd9; rc_addr = 7'd4;
        bus[6] = mk(1'b1, 4'd3, 7'd9, Y);
        bus[7] = mk(1'b1, 4'd1, 7'd4, X);
        wb_en = 1'b1; wb_addr = 7'd9; wb_data = Z;
        issue_valid = 1'b1;
        #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL prio_issue_ready got=%0b exp=1", issue_ready); end
        tick();
        total++; if (ex_ra_data !== Y) begin bad++; $display("FAIL prio_ex_ra got=%h exp=%h", ex_ra_data, Y); end
        total++; if (ex_rb_data !== Y) begin bad++; $display("FAIL prio_ex_rb got=%h exp=%h", ex_rb_data, Y); end
        total++; if (ex_rc_data !== X) begin bad++; $display("FAIL prio_ex_rc got=%h exp=%h", ex_rc_data, X); end
        // WB only, then RF for unmatched
        bus[6] = '0; bus[7] = '0;
        wb_addr = 7'd4;
        tick();
        issue_valid = 1'b0;
        total++; if (ex_rc_data !== Z) begin bad++; $display("FAIL wb_ex_rc got=%h exp=%h", ex_rc_data, Z); end
        total++; if (ex_ra_data !== A) begin bad++; $display("FAIL wb_ex_ra_rf got=%h exp=%h", ex_ra_data, A); end
        tick();
    endtask

    task automatic test_timeout();
        clear_inputs();
        rb_addr = 7'd7;
        bus[1] = mk(1'b1, 4'd4, 7'd7, X);
        issue_valid = 1'b1;
        for (int c = 0; c < 15; c++) tick();
        total++; if (stall_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early got=%0b exp=0", stall_timeout); end
        tick();
        total++; if (stall_timeout !== 1'b1) begin bad++; $display("FAIL timeout_set got=%0b exp=1", stall_timeout); end
        bus[1] = '0;
        tick();
        total++; if (ex_valid !== 1'b1)      begin bad++; $display("FAIL timeout_release_ex got=%0b exp=1", ex_valid); end
        tick();
        issue_valid = 1'b0;
        total++; if (stall_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%0b exp=1", stall_timeout); end
        total++; if (stall !== 1'b0)         begin bad++; $display("FAIL timeout_stall_clear got=%0b exp=0", stall); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        ra_addr = 7'd8;
        bus[2] = mk(1'b1, 4'd6, 7'd8, X);
        issue_valid = 1'b1;
        tick(); tick();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mid_stall_pre got=%0b exp=1", stall); end
        rst = 1'b0;
        #1;
        total++; if (stall !== 1'b0)         begin bad++; $display("FAIL mid_rst_stall got=%0b exp=0", stall); end
        total++; if (ex_valid !== 1'b0)      begin bad++; $display("FAIL mid_rst_ex_valid got=%0b exp=0", ex_valid); end
        total++; if (stall_timeout !== 1'b0) begin bad++; $display("FAIL mid_rst_timeout got=%0b exp=0", stall_timeout); end
        total++; if (ex_ra_data !== '0)      begin bad++; $display("FAIL mid_rst_ex_ra got=%h exp=0", ex_ra_data); end
        tick();
        rst = 1'b1;
        bus[2] = '0;
        tick();
        issue_valid = 1'b0;
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL resume_ex_valid got=%0b exp=1", ex_valid); end
        total++; if (ex_ra_data !== A)  begin bad++; $display("FAIL resume_ex_ra got=%h exp=%h", ex_ra_data, A); end
        total++; if (stall !== 1'b0)    begin bad++; $display("FAIL resume_stall got=%0b exp=0", stall); end
        tick();
    endtask

    initial begin
        test_reset();
        test_rf_path();
        test_stage_fwd();
        test_stall_advance();
        test_priority();
        test_timeout();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
